// File: rtl/munoc_rdata_upsizer_if.sv
// Command, narrow R and wide R signals of the MUNOC read-data upsizer.
// The slave modport is the upsizer's view, the master modport is its environment's.
interface munoc_rdata_upsizer_if #(
  parameter int BW_NARROW_DATA = 32,
  parameter int BW_WIDE_DATA   = 128,
  parameter int BW_OFFSET      = $clog2(BW_WIDE_DATA / 8)
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [BW_OFFSET-1:0]      cmd_offset;
  logic [2:0]                cmd_size;
  logic [7:0]                cmd_len;

  logic                      s_rvalid;
  logic                      s_rready;
  logic [BW_NARROW_DATA-1:0] s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rlast;

  logic                      m_rvalid;
  logic                      m_rready;
  logic [BW_WIDE_DATA-1:0]   m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;

  logic                      last_mismatch;

  modport slave (
    input  cmd_valid, cmd_offset, cmd_size, cmd_len,
    output cmd_ready,
    input  s_rvalid, s_rdata, s_rresp, s_rlast,
    output s_rready,
    output m_rvalid, m_rdata, m_rresp, m_rlast,
    input  m_rready,
    output last_mismatch
  );

  modport master (
    output cmd_valid, cmd_offset, cmd_size, cmd_len,
    input  cmd_ready,
    output s_rvalid, s_rdata, s_rresp, s_rlast,
    input  s_rready,
    input  m_rvalid, m_rdata, m_rresp, m_rlast,
    output m_rready,
    input  last_mismatch
  );
endinterface

// File: rtl/munoc_rdata_upsizer.sv
// AXI read-data upsizer: packs narrow slave R beats into wide master R beats.
// Narrow transfers (size <= narrow width) are replicated across all lanes;
// wider transfers are assembled lane by lane in an accumulator.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ACTIVE | accepting narrow beats and emitting wide beats
// DRAIN  | final wide beat loaded, waiting for it to be taken
module munoc_rdata_upsizer #(
  parameter int BW_NARROW_DATA = 32,
  parameter int BW_WIDE_DATA   = 128,
  parameter int BW_OFFSET      = $clog2(BW_WIDE_DATA / 8)
) (
  input logic clk,
  input logic rstnn,
  munoc_rdata_upsizer_if.slave bus
);
  localparam int RATIO  = BW_WIDE_DATA / BW_NARROW_DATA;
  localparam int LW     = $clog2(RATIO);
  localparam int NB_LOG = $clog2(BW_NARROW_DATA / 8);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                                 state;
  logic                                   pass_q;
  logic [LW-1:0]                          gmask_q;
  logic [LW-1:0]                          lane_ptr;
  logic [7:0]                             len_q;
  logic [7:0]                             beat_cnt;
  logic [RATIO-1:0][BW_NARROW_DATA-1:0]   acc_data;
  logic [1:0]                             acc_resp;
  logic                                   cmd_ready_q;
  logic                                   m_rvalid_q;
  logic [BW_WIDE_DATA-1:0]                m_rdata_q;
  logic [1:0]                             m_rresp_q;
  logic                                   m_rlast_q;

  logic [BW_OFFSET-1:0]                   offset_c;
  logic [LW-1:0]                          gmask_c;
  logic [LW-1:0]                          lane_init_c;
  logic                                   group_start;
  logic                                   completing;
  logic                                   final_beat;
  logic                                   s_rready_c;
  logic                                   s_fire;
  logic                                   load;
  logic [RATIO-1:0][BW_NARROW_DATA-1:0]   merge_data;
  logic [1:0]                             merge_resp;
  logic [BW_WIDE_DATA-1:0]                load_data;
  logic [1:0]                             load_resp;

  assign offset_c = bus.cmd_offset;

  // Group mask (G-1) from the requested size, and the group-aligned start lane.
  always_comb begin
    gmask_c = '0;
    for (int i = 0; i < LW; i++) begin
      gmask_c[i] = (int'(bus.cmd_size) > NB_LOG + i);
    end
    lane_init_c = LW'(offset_c >> NB_LOG) & ~gmask_c;
  end

  assign group_start = ((lane_ptr & gmask_q) == '0);
  assign completing  = pass_q | ((lane_ptr & gmask_q) == gmask_q);
  assign final_beat  = (beat_cnt == len_q);
  assign s_rready_c  = (state == ACTIVE) & (~completing | ~m_rvalid_q | bus.m_rready);
  assign s_fire      = bus.s_rvalid & s_rready_c;
  assign load        = s_fire & completing;

  // Merge the current narrow beat into the accumulator view; a new group starts from zero.
  always_comb begin
    merge_data           = group_start ? '0 : acc_data;
    merge_data[lane_ptr] = bus.s_rdata;
    merge_resp           = (group_start || (bus.s_rresp > acc_resp)) ? bus.s_rresp : acc_resp;
    load_data            = pass_q ? {RATIO{bus.s_rdata}} : merge_data;
    load_resp            = pass_q ? bus.s_rresp : merge_resp;
  end

  // Sequencer, accumulator and wide output register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state       <= IDLE;
      pass_q      <= 1'b0;
      gmask_q     <= '0;
      lane_ptr    <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      acc_data    <= '0;
      acc_resp    <= '0;
      cmd_ready_q <= 1'b1;
      m_rvalid_q  <= 1'b0;
      m_rdata_q   <= '0;
      m_rresp_q   <= '0;
      m_rlast_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state       <= ACTIVE;
            cmd_ready_q <= 1'b0;
            pass_q      <= (int'(bus.cmd_size) <= NB_LOG);
            gmask_q     <= gmask_c;
            lane_ptr    <= lane_init_c;
            len_q       <= bus.cmd_len;
            beat_cnt    <= '0;
          end
        end
        ACTIVE: begin
          if (load && final_beat) state <= DRAIN;
        end
        DRAIN: begin
          if (m_rvalid_q && bus.m_rready && m_rlast_q) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (s_fire && !pass_q) begin
        acc_data <= merge_data;
        acc_resp <= merge_resp;
        lane_ptr <= lane_ptr + LW'(1);
      end

      if (m_rvalid_q && bus.m_rready) begin
        m_rvalid_q <= 1'b0;
        m_rlast_q  <= 1'b0;
      end

      // A load on the same cycle as a drain keeps the register full.
      if (load) begin
        m_rvalid_q <= 1'b1;
        m_rdata_q  <= load_data;
        m_rresp_q  <= load_resp;
        m_rlast_q  <= final_beat;
        beat_cnt   <= beat_cnt + 8'd1;
      end
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.s_rready      = s_rready_c;
  assign bus.m_rvalid      = m_rvalid_q;
  assign bus.m_rdata       = m_rdata_q;
  assign bus.m_rresp       = m_rresp_q;
  assign bus.m_rlast       = m_rlast_q;
  assign bus.last_mismatch = s_fire & (bus.s_rlast != (completing & final_beat));
endmodule

// File: doc/munoc_rdata_upsizer.md
Name: munoc_rdata_upsizer

Overview:
AXI read-data width upsizer in the MUNOC slave-side network interface. It collects narrow R beats from a slave whose bus is BW_NARROW_DATA wide and packs them into wide R beats for a master whose bus is BW_WIDE_DATA wide. It is the read-direction counterpart of the write-data downsizer. Each transaction's parameters are loaded through a command handshake before any data is accepted.

Parameters:
BW_NARROW_DATA, 32, slave-side data width; power of 2, at least 32
BW_WIDE_DATA, 128, master-side data width; power of 2; BW_WIDE_DATA/BW_NARROW_DATA (RATIO) must be at least 2
BW_OFFSET, log2(BW_WIDE_DATA/8), byte-offset bits within one wide word

Ports:
clk  in  1  clock
rstnn  in  1  reset; asynchronous and active-low (clock `clk`, reset `rstnn`)
cmd_valid  in  1  transaction parameters valid
cmd_ready  out  1  high while the block is idle
cmd_offset  in  BW_OFFSET  araddr low bits
cmd_size  in  3  AXI arsize; never exceeds log2(BW_WIDE_DATA/8)
cmd_len  in  8  AXI arlen (master-side beats minus 1)
s_rvalid  in  1  narrow R valid
s_rready  out  1  narrow R ready
s_rdata  in  BW_NARROW_DATA  narrow read data
s_rresp  in  2  narrow response
s_rlast  in  1  narrow last
m_rvalid  out  1  wide R valid
m_rready  in  1  wide R ready
m_rdata  out  BW_WIDE_DATA  wide read data
m_rresp  out  2  merged response
m_rlast  out  1  last wide beat of the transaction
last_mismatch  out  1  one-cycle pulse on a narrow rlast protocol error

Behaviour:
Definitions:
- NB = BW_NARROW_DATA/8
- SB = 2^cmd_size, captured per command
- Mode is PASS when SB <= NB, otherwise PACK.
- In PACK, G = SB/NB lanes per wide beat.

Reset:
- State goes to IDLE.
- All counters, accumulator, output register and flags clear.
- Outputs: m_rvalid=0, m_rdata=0, m_rresp=0, m_rlast=0, s_rready=0, cmd_ready=1, last_mismatch=0.
- Reset asserted mid-transaction abandons the transaction; there is no drain.

State machine: IDLE, ACTIVE, DRAIN.
- IDLE -> ACTIVE on cmd_valid & cmd_ready. Capture offset, size, len and mode.
  - Lane pointer = (cmd_offset >> log2(NB)) with its low log2(G) bits cleared in PACK.
  - Beat counter = 0.
- ACTIVE -> DRAIN when the narrow beat completing wide beat number cmd_len is accepted.
- DRAIN -> IDLE on the m_rvalid & m_rready handshake with m_rlast=1.
- cmd_ready = (state == IDLE).

Narrow side:
- s_rready = ACTIVE & (beat is non-completing, OR output register empty, OR m_rready).
- Non-completing beats therefore never stall.
- A PASS beat always counts as completing.
- A PACK beat is completing when the lane pointer's low log2(G) bits are all ones.

PASS mode:
- Each accepted narrow beat is loaded into the output register with s_rdata replicated in all RATIO lanes, and m_rresp = s_rresp.

PACK mode:
- Accepted data is written into lane [lane pointer] of the accumulator.
- The lane pointer increments modulo RATIO.
- At the start of a group, all lanes other than the written one are zeroed.
- The response accumulator holds the numeric maximum of s_rresp over the group: OKAY=0 < EXOKAY=1 < SLVERR=2 < DECERR=3. It resets at group start.
- The completing beat moves accumulator plus the current beat into the output register. That beat's data and resp are merged combinationally on the same cycle.

Output register:
- m_rvalid rises the cycle after the completing narrow beat is accepted (latency 1).
- m_rvalid holds with stable data until m_rready.
- Load and drain on the same cycle are allowed, giving full throughput.
- m_rlast = 1 when the beat counter equals the captured cmd_len at the time of loading.
- The beat counter increments on each load.

Protocol check:
- last_mismatch pulses for one cycle when an accepted narrow beat has s_rlast differing from "this is the completing beat of the final wide beat".
- Data is still forwarded, and the expected count governs termination.

Wrap-around: the lane pointer wraps from RATIO-1 to 0 with no bubble.

Test Plan:
1. PASS, 32 to 128: offset=0x4, size=2, len=3; narrow data 0xA0..0xA3 -> 4 wide beats, each lane = narrow word, e.g. beat 0 = {4{0xA0}}; m_rlast only on the 4th beat; cmd_ready returns high after it.
2. PACK full width: size=4, len=1, offset=0; 8 narrow beats D0..D7 -> beat 0 = {D3,D2,D1,D0}, beat 1 = {D7..D4}; rresp OKAY.
3. PACK partial: size=3 (G=2), offset=0x8, len=2 -> lanes start at 2; beat 0 = {D1,D0,0,0}, beat 1 = {0,0,D3,D2}, beat 2 = {D5,D4,0,0}, showing lane wrap.
4. Response merge: size=4, narrow resp OKAY, SLVERR, OKAY, EXOKAY -> m_rresp=SLVERR; next group all OKAY -> OKAY.
5. Backpressure: m_rready held low 5 cycles in PACK -> non-completing beats are accepted; s_rready drops only on the completing beat; no data loss; full throughput once m_rready=1.
6. s_rlast asserted on narrow beat 2 of 8 -> last_mismatch pulse that cycle, transfer completes normally. rstnn pulsed low mid-transfer -> m_rvalid=0, cmd_ready=1 immediately.
